// File: rtl/stopwatch_scan_ctrl_if.sv
// Control and display bundle for stopwatch_scan_ctrl.
// Player logic drives the master side; the timer/scan block is the slave side.
interface stopwatch_scan_ctrl_if;
    logic        ena;
    logic        st;
    logic        back;
    logic        load;
    logic [23:0] preset;
    logic [7:0]  oSel;
    logic [6:0]  oData;
    logic [23:0] time_bcd;
    logic        done;
    logic        err;

    // load is a one-cycle strobe sampled on clk; done and err are one-cycle strobes back.
    modport master (
        output ena, st, back, load, preset,
        input  oSel, oData, time_bcd, done, err
    );

    modport slave (
        input  ena, st, back, load, preset,
        output oSel, oData, time_bcd, done, err
    );
endinterface

// File: rtl/stopwatch_scan_ctrl.sv
// HH:MM:SS BCD up/down timer with an 8-digit multiplexed seven-segment driver.
// Everything runs on clk; count and scan advance on single-cycle enables.
module stopwatch_scan_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int SCAN_HZ    = 1000,
    parameter int HOUR_MAX   = 23,
    parameter bit ACTIVE_LOW = 1
) (
    input logic clk,
    input logic rst,
    stopwatch_scan_ctrl_if.slave bus
);
    localparam int TDIV = CLK_HZ / TICK_HZ;
    localparam int SDIV = CLK_HZ / SCAN_HZ;
    localparam int TW   = $clog2(TDIV);
    localparam int SW   = $clog2(SDIV);
    localparam logic [TW-1:0] TLAST        = TW'(TDIV - 1);
    localparam logic [SW-1:0] SLAST        = SW'(SDIV - 1);
    localparam logic [7:0]    HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [23:0]   WRAP_AT      = {HOUR_MAX_BCD, 16'h5959};
    // Largest value of each digit position, ss_l in the low nibble.
    localparam logic [23:0]   DIG_TOP      = 24'h995959;
    localparam logic [7:0]    SEL_OFF      = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0]    SEG_OFF      = ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic logic [3:0] inc_d(input logic [3:0] d, input logic [3:0] top);
        return (d == top) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec_d(input logic [3:0] d, input logic [3:0] top);
        return (d == 4'd0) ? top : d - 4'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [TW-1:0] tcnt;
    logic          tick;
    logic [23:0]   cnt, cnt_up, cnt_dn, cnt_nxt;
    logic          preset_ok;
    logic          done_q, err_q;

    assign tick = bus.st && (tcnt == TLAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (!bus.st || bus.load || tcnt == TLAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Carry/borrow ripple: a digit moves only when every lower digit is at its limit.
    always_comb begin : step_calc
        logic       c, b;
        logic [3:0] d, t;
        c      = 1'b1;
        b      = 1'b1;
        cnt_up = cnt;
        cnt_dn = cnt;
        for (int i = 0; i < 6; i++) begin
            d = cnt[4*i +: 4];
            t = DIG_TOP[4*i +: 4];
            cnt_up[4*i +: 4] = c ? inc_d(d, t) : d;
            cnt_dn[4*i +: 4] = b ? dec_d(d, t) : d;
            c = c && (d == t);
            b = b && (d == 4'd0);
        end
        if (cnt == WRAP_AT) begin
            cnt_up = '0;
        end
    end

    always_comb begin
        preset_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.preset[4*i +: 4] > 4'd9) preset_ok = 1'b0;
        end
        if (bus.preset[7:4] > 4'd5 || bus.preset[15:12] > 4'd5) preset_ok = 1'b0;
        if (bus.preset[23:16] > HOUR_MAX_BCD) preset_ok = 1'b0;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (bus.load) begin
            cnt_nxt = preset_ok ? bus.preset : cnt;
        end else if (tick) begin
            if (!bus.back)          cnt_nxt = cnt_up;
            else if (cnt != 24'd0)  cnt_nxt = cnt_dn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            done_q <= !bus.load && tick && bus.back && (cnt != 24'd0) && (cnt_dn == 24'd0);
            err_q  <= bus.load && !preset_ok;
        end
    end

    logic [SW-1:0] scnt;
    logic [2:0]    pos;
    logic [3:0]    digit;
    logic          dash;
    logic [6:0]    glyph;
    logic [7:0]    sel_q;
    logic [6:0]    seg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= '0;
            pos  <= '0;
        end else if (scnt == SLAST) begin
            scnt <= '0;
            pos  <= pos + 3'd1;
        end else begin
            scnt <= scnt + SW'(1);
        end
    end

    always_comb begin
        digit = 4'd0;
        dash  = 1'b0;
        case (pos)
            3'd0:    digit = cnt[3:0];
            3'd1:    digit = cnt[7:4];
            3'd3:    digit = cnt[11:8];
            3'd4:    digit = cnt[15:12];
            3'd6:    digit = cnt[19:16];
            3'd7:    digit = cnt[23:20];
            default: dash  = 1'b1;
        endcase
        glyph = dash ? 7'b1000000 : seg7(digit);
    end

    // XOR with the inactive level applies the pin polarity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= SEL_OFF;
            seg_q <= SEG_OFF;
        end else begin
            sel_q <= bus.ena ? ((8'd1 << pos) ^ SEL_OFF) : SEL_OFF;
            seg_q <= bus.ena ? (glyph ^ SEG_OFF) : SEG_OFF;
        end
    end

    assign bus.oSel     = sel_q;
    assign bus.oData    = seg_q;
    assign bus.time_bcd = cnt;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_stopwatch_scan_ctrl.sv
// Bench for stopwatch_scan_ctrl: seconds-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized control traffic.
module tb_stopwatch_scan_ctrl;
    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int SCAN_HZ  = 50;
    localparam int HOUR_MAX = 23;
    localparam int TDIV     = CLK_HZ / TICK_HZ;
    localparam int SDIV     = CLK_HZ / SCAN_HZ;
    localparam int DAY      = (HOUR_MAX + 1) * 3600;

    logic clk = 1'b0;
    logic rst;

    stopwatch_scan_ctrl_if bus();

    stopwatch_scan_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ),
        .HOUR_MAX(HOUR_MAX), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0] sel_seq [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    function automatic logic [23:0] sec_to_bcd(input int s);
        int hh = s / 3600;
        int mm = (s / 60) % 60;
        int ss = s % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int bcd_to_sec(input logic [23:0] p);
        return (int'(p[23:20]) * 10 + int'(p[19:16])) * 3600
             + (int'(p[15:12]) * 10 + int'(p[11:8])) * 60
             + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic bit preset_ok(input logic [23:0] p);
        bit ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (p[4*i +: 4] > 9) ok = 1'b0;
        end
        if (p[7:4] > 5 || p[15:12] > 5) ok = 1'b0;
        if (int'(p[23:20]) * 10 + int'(p[19:16]) > HOUR_MAX) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [6:0] glyph_at(input int p, input int s);
        int hh = s / 3600;
        int mm = (s / 60) % 60;
        int ss = s % 60;
        int digs [8];
        digs = '{ss % 10, ss / 10, -1, mm % 10, mm / 10, -1, hh % 10, hh / 10};
        return (digs[p] < 0) ? 7'b1000000 : seg_tab[digs[p]];
    endfunction

    function automatic bit is_tick(input logic st_now, input int run);
        return st_now && (run % TDIV == TDIV - 1);
    endfunction

    // Reference model: count kept as plain seconds, scan position derived from cycles since reset.
    int         m_sec, m_run, m_scan;
    logic       m_done, m_err;
    logic [7:0] m_sel;
    logic [6:0] m_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sec  <= 0;
            m_run  <= 0;
            m_scan <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_sel  <= 8'hFF;
            m_data <= 7'h7F;
        end else begin
            m_sel  <= bus.ena ? ~(8'd1 << ((m_scan / SDIV) % 8)) : 8'hFF;
            m_data <= bus.ena ? ~glyph_at((m_scan / SDIV) % 8, m_sec) : 7'h7F;
            m_err  <= bus.load && !preset_ok(bus.preset);
            m_done <= !bus.load && is_tick(bus.st, m_run) && bus.back && (m_sec == 1);
            if (bus.load) begin
                if (preset_ok(bus.preset)) m_sec <= bcd_to_sec(bus.preset);
            end else if (is_tick(bus.st, m_run)) begin
                if (bus.back) m_sec <= (m_sec > 0) ? m_sec - 1 : 0;
                else          m_sec <= (m_sec + 1) % DAY;
            end
            m_run  <= (!bus.st || bus.load) ? 0 : m_run + 1;
            m_scan <= m_scan + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare all outputs mid-cycle, then return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        chk("time_bcd", bus.time_bcd, sec_to_bcd(m_sec));
        chk("done", bus.done, m_done);
        chk("err", bus.err, m_err);
        chk("oSel", bus.oSel, m_sel);
        chk("oData", bus.oData, m_data);
        if (bus.done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [23:0] v);
        bus.load   = 1'b1;
        bus.preset = v;
        step();
        bus.load   = 1'b0;
    endtask

    function automatic logic [23:0] rand_preset();
        logic [23:0] r;
        case ($urandom_range(0, 3))
            0:       r = 24'($urandom);
            1:       r = sec_to_bcd(int'($urandom_range(0, 30)));
            default: r = sec_to_bcd(int'($urandom_range(0, DAY - 1)));
        endcase
        return r;
    endfunction

    initial begin
        bit found;
        rst        = 1'b0;
        bus.ena    = 1'b1;
        bus.st     = 1'b0;
        bus.back   = 1'b0;
        bus.load   = 1'b0;
        bus.preset = 24'h0;
        repeat (3) step();
        chk("rst_sel", bus.oSel, 8'hFF);
        chk("rst_data", bus.oData, 7'h7F);
        chk("rst_time", bus.time_bcd, 24'h0);

        // First count lands TDIV cycles after release with st high.
        rst    = 1'b1;
        bus.st = 1'b1;
        repeat (9) step();
        chk("first_tick_hold", bus.time_bcd, 24'h000000);
        step();
        chk("first_tick", bus.time_bcd, 24'h000001);

        // Up-count wrap at HOUR_MAX:59:59.
        done_cnt = 0;
        pulse_load(24'h235958);
        chk("up_load", bus.time_bcd, 24'h235958);
        repeat (10) step();
        chk("up_5959", bus.time_bcd, 24'h235959);
        repeat (10) step();
        chk("up_wrap", bus.time_bcd, 24'h000000);
        chk("up_no_done", done_cnt, 0);

        // Countdown with hour borrow, then to zero and hold.
        bus.back = 1'b1;
        pulse_load(24'h010000);
        repeat (10) step();
        chk("dn_borrow", bus.time_bcd, 24'h005959);
        done_cnt = 0;
        pulse_load(24'h000002);
        repeat (10) step();
        chk("dn_one", bus.time_bcd, 24'h000001);
        repeat (10) step();
        chk("dn_zero", bus.time_bcd, 24'h000000);
        chk("dn_done_now", bus.done, 1'b1);
        repeat (50) step();
        chk("dn_hold", bus.time_bcd, 24'h000000);
        chk("dn_done_once", done_cnt, 1);

        // Preset validation.
        bus.st = 1'b0;
        pulse_load(24'h120000);
        chk("ld_valid", bus.time_bcd, 24'h120000);
        pulse_load(24'h246000);
        chk("ld_bad_hour_err", bus.err, 1'b1);
        chk("ld_bad_hour_keep", bus.time_bcd, 24'h120000);
        step();
        chk("err_one_cycle", bus.err, 1'b0);
        pulse_load(24'h001061);
        chk("ld_bad_sec_err", bus.err, 1'b1);
        chk("ld_bad_sec_keep", bus.time_bcd, 24'h120000);

        // Load coincident with a tick wins and restarts the period.
        bus.back = 1'b0;
        bus.st   = 1'b1;
        for (int i = 0; i < 2 * TDIV && (m_run % TDIV) != TDIV - 1; i++) step();
        pulse_load(24'h000000);
        chk("ld_tick_val", bus.time_bcd, 24'h000000);
        chk("ld_tick_err", bus.err, 1'b0);
        repeat (9) step();
        chk("ld_tick_restart_hold", bus.time_bcd, 24'h000000);
        step();
        chk("ld_tick_restart", bus.time_bcd, 24'h000001);

        // Scan order and glyphs for 12:34:56.
        bus.st = 1'b0;
        pulse_load(24'h123456);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.oSel == 8'hFE) found = 1'b1;
            else step();
        end
        chk("scan_sync", found, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("scan_sel", bus.oSel, sel_seq[k]);
            if (k == 0) chk("scan_digit6", bus.oData, 7'b0000010);
            if (k == 2) chk("scan_dash", bus.oData, 7'b0111111);
            step();
            step();
        end

        // Pause discards the partial period; disable blanks within one cycle.
        bus.st = 1'b1;
        repeat (5) step();
        bus.st = 1'b0;
        repeat (25) step();
        chk("pause_hold", bus.time_bcd, 24'h123456);
        bus.st = 1'b1;
        repeat (9) step();
        chk("resume_hold", bus.time_bcd, 24'h123456);
        step();
        chk("resume_tick", bus.time_bcd, 24'h123457);
        bus.ena = 1'b0;
        step();
        chk("dis_sel", bus.oSel, 8'hFF);
        chk("dis_data", bus.oData, 7'h7F);
        bus.ena = 1'b1;

        // Asynchronous reset in the middle of a period.
        repeat (7) step();
        #2 rst = 1'b0;
        #1;
        chk("arst_time", bus.time_bcd, 24'h000000);
        chk("arst_sel", bus.oSel, 8'hFF);
        step();
        rst = 1'b1;
        repeat (9) step();
        chk("arst_resume_hold", bus.time_bcd, 24'h000000);
        step();
        chk("arst_resume", bus.time_bcd, 24'h000001);

        // Randomized control traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0)  bus.st   = !bus.st;
            if ($urandom_range(0, 29) == 0) bus.back = !bus.back;
            if ($urandom_range(0, 19) == 0) bus.ena  = !bus.ena;
            bus.load = ($urandom_range(0, 24) == 0);
            if (bus.load) bus.preset = rand_preset();
            step();
        end
        bus.load = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_scan_ctrl.md
# stopwatch_scan_ctrl

Parametrised HH:MM:SS up/down timer with an integrated 8-digit multiplexed 7-segment driver. It runs entirely on the system clock using single-cycle tick enables; there are no derived clocks. Countdown stops at zero and raises a `done` pulse. Presets are range-checked before loading. It sits between the player control logic (run, load and direction) and the board's seven-segment display pins.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `TICK_HZ`, default 1: count rate. The divisor is `TDIV = CLK_HZ/TICK_HZ`, which must be ≥ 2.
- `SCAN_HZ`, default 1000: digit-step rate. The divisor is `SDIV = CLK_HZ/SCAN_HZ`, which must be ≥ 2.
- `HOUR_MAX`, default 23: largest hour value, 1..99, compared as a BCD pair.
- `ACTIVE_LOW`, default 1: when 1, `oSel` and `oData` are active-low; when 0, they are active-high.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `ena`, in, 1: display enable. When 0, all digits are dark; counting is unaffected.
- `st`, in, 1: run (1) or pause (0).
- `back`, in, 1: direction; 0 counts up, 1 counts down.
- `load`, in, 1: single-cycle pulse that loads `preset`.
- `preset`, in, 24: BCD value `{hh_h, hh_l, mm_h, mm_l, ss_h, ss_l}`.
- `oSel`, out, 8: digit select, one-hot; bit 7 is the leftmost digit.
- `oData`, out, 7: segments `{g,f,e,d,c,b,a}`; `oData[0]` is segment a.
- `time_bcd`, out, 24: current value, same format as `preset`.
- `done`, out, 1: single-cycle pulse when a countdown reaches 00:00:00.
- `err`, out, 1: single-cycle pulse when a `load` is rejected.

## Operation
- **Tick divider:** `tcnt` runs 0..TDIV-1 only while `st`=1. The `tick` enable is asserted in the cycle where `tcnt`=TDIV-1. `tcnt` is cleared whenever `st`=0 or `load`=1.
- **Up count** (`back`=0), on `tick`: BCD ripple through ss_l 9→0, ss_h 5→0, mm_l 9→0, mm_h 5→0. Hours increment up to `HOUR_MAX`. HOUR_MAX:59:59 wraps to 00:00:00; no `done` pulse.
- **Down count** (`back`=1), on `tick`: BCD borrow chain, with ss_l 0→9, ss_h 0→5 and likewise for minutes. A borrow into the hours decrements the hours BCD correctly, e.g. 10→09.
  - When the value becomes 000000, `done` pulses in the following cycle.
  - At 000000 the count holds; later ticks produce no change and no `done`.
- **Preset validation:** a preset is valid only if:
  - every digit is ≤ 9;
  - ss_h ≤ 5 and mm_h ≤ 5;
  - the hour pair is ≤ `HOUR_MAX`.
- **Load:** a valid preset is copied to the count. An invalid preset leaves the count unchanged and pulses `err` in the next cycle.
  - `load` has priority over `tick` in the same cycle.
- **Direction change:** a change of `back` mid-run takes effect at the next `tick`.
- **Scan:** position counter `pos` 0..7 advances every SDIV cycles, wrapping 7→0.
  - Positions 0, 1, 3, 4, 6, 7 show ss_l, ss_h, mm_l, mm_h, hh_l, hh_h respectively.
  - Positions 2 and 5 show a dash (segment g only).
  - Selected position p drives `oSel` bit p active.
- **Decode:** standard hex 0–9; codes above 9 are blank. Active-high patterns: 0=0111111, 1=0000110, 8=1111111, dash=1000000. With `ACTIVE_LOW`=1 these are inverted.
- **Display disable:** `ena`=0 forces `oSel` and `oData` to the all-inactive level. Scan and count continue.

## Timing
- **Reset values:** count 000000; `tcnt`=0; `pos`=0; `done`=0; `err`=0; `oSel`/`oData` all inactive (8'hFF and 7'h7F when `ACTIVE_LOW`=1).
- **Output latency:**
  - `time_bcd` updates in the cycle after `tick`, or after `load`.
  - `oSel`/`oData` are registered and reflect `pos` and the count one cycle after `pos` changes.
  - An `ena` change is visible after 1 cycle.
- **First tick:** the first count change occurs exactly TDIV cycles after `st` rises, or after a `load`.
- **Reset mid-operation:** `rst` low clears everything immediately (asynchronous). Release is synchronous to the next clk edge; the count resumes only after TDIV further cycles with `st`=1.
- **Pause:** `st` dropping mid-period discards the partial period.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (TDIV=10), SCAN_HZ=50 (SDIV=2), HOUR_MAX=23, ACTIVE_LOW=1.
1. **Reset:** hold `rst`=0, then release with `st`=1. Require `time_bcd`=000000 until cycle 10, then 000001; `oSel`/`oData`=FF/7F during reset.
2. **Up wrap:** load 235958 with `back`=0, `st`=1. Require 235959, then 000000 after 2 ticks; `done` stays 0.
3. **Countdown:** load 010000 with `back`=1. Require 005959 after 1 tick. Then load 000002: require 000001, then 000000 with exactly one `done` pulse; 000000 holds for 5 more ticks.
4. **Preset check:** load 246000, then 001061. Require `err` pulses and the count unchanged. Load 000000 with `load` coincident with a `tick`: require 000000, `tcnt` restarted, and `err`=0.
5. **Scan:** count 123456, `ena`=1. Over 16 cycles `oSel` steps FE, FD, FB, … 7F. At `pos`=2 `oData`=0111111 (dash). At `pos`=0 `oData` is the inverted pattern for 6 (1111101 active-high, so 0000010 on the pins).
6. **Pause and disable:** `st`=0 for 25 cycles, then `st`=1. Require no count change until 10 cycles after re-assertion. `ena`=0 forces `oSel`=FF and `oData`=7F within 1 cycle.
